register_file_mp: RTL and testbench

- Parametrised multi-read-port register file for the CPU datapath; successor to the single-port register file.
- Provides NUM_READ synchronous read ports and one write port.
- Optional hardwired-zero entry 0 and optional write-to-read bypass.
- After reset, a sequential clear sweep zeroes every entry; busy is asserted while the sweep runs.

---
 rtl/regfile_pkg.sv | 22 ++
 rtl/regfile_read_port.sv | 58 +++++
 rtl/register_file_mp.sv | 128 ++++++++++++
 tb/tb_register_file_mp.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-read-port register file.
//   state_e   : clear-sweep FSM states
//   depth_of  : number of entries for a given address width
//   slice_lo  : low bit offset of a port's field inside a packed port bus
package regfile_pkg;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_e;

  // Entry count for an address width.
  function automatic int unsigned depth_of(input int unsigned addr_w);
    return 32'd1 << addr_w;
  endfunction

  // Low bit of field idx in a bus packed as idx*width +: width.
  function automatic int unsigned slice_lo(input int unsigned idx, input int unsigned width);
    return idx * width;
  endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One synchronous read port of the register file.
// Ports:
//   clk, rst     clock and synchronous active-high reset
//   clear_i      sweep in progress: enabled reads return 0
//   rd_en_i      read enable; when low the output register holds
//   rd_addr_i    read address
//   wr_en_i      write strobe seen in READY (for forwarding)
//   wr_addr_i    write address
//   wr_data_i    write data
//   arr_data_i   array contents at rd_addr_i before this edge
//   rd_data_o    registered read data
module regfile_read_port #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [DATA_W-1:0] arr_data_i,
  output logic [DATA_W-1:0] rd_data_o
);

  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              hit_zero_c;
  logic              hit_bypass_c;

  assign hit_zero_c   = ZERO_REG && (rd_addr_i == '0);
  assign hit_bypass_c = BYPASS && wr_en_i && (wr_addr_i == rd_addr_i);

  // Zero entry beats forwarding, forwarding beats the stored value.
  always_comb begin
    rd_data_d = arr_data_i;
    if (clear_i || hit_zero_c) begin
      rd_data_d = '0;
    end else if (hit_bypass_c) begin
      rd_data_d = wr_data_i;
    end
  end

  // Output register with hold when the port is idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q <= '0;
    end else if (rd_en_i) begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/register_file_mp.sv
// Multi-read-port register file with one write port, optional hardwired
// zero entry, optional write-to-read forwarding and a post-reset clear sweep.
// Ports:
//   clk           clock, all logic on posedge
//   rst           synchronous active-high reset; restarts the clear sweep
//   rd_en         per-port read enable
//   rd_addr       packed read addresses, port i at [i*ADDR_W +: ADDR_W]
//   rd_data       packed registered read data, port i at [i*DATA_W +: DATA_W]
//   write_enable  write strobe (ignored while busy)
//   wr_addr       write address
//   data_in       write data
//   busy          high while the clear sweep runs
module register_file_mp
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NUM_READ = 2,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_READ-1:0]          rd_en,
  input  logic [NUM_READ*ADDR_W-1:0]   rd_addr,
  output logic [NUM_READ*DATA_W-1:0]   rd_data,
  input  logic                         write_enable,
  input  logic [ADDR_W-1:0]            wr_addr,
  input  logic [DATA_W-1:0]            data_in,
  output logic                         busy
);

  localparam int unsigned       DEPTH    = depth_of(ADDR_W);
  localparam logic [ADDR_W-1:0] CLR_LAST = '1;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic              busy_q, busy_d;

  logic              user_wr_c;
  logic              port_wr_c;
  logic              mem_we_c;
  logic [ADDR_W-1:0] mem_waddr_c;
  logic [DATA_W-1:0] mem_wdata_c;

  logic [DATA_W-1:0] mem_q [DEPTH];

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= CLEAR;
      clr_cnt_q <= '0;
      busy_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      busy_q    <= busy_d;
    end
  end

  // Next state: walk every entry once, leave CLEAR after the last one.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    unique case (state_q)
      CLEAR: begin
        clr_cnt_d = clr_cnt_q + ADDR_W'(1);
        if (clr_cnt_q == CLR_LAST) begin
          state_d = READY;
        end
      end
      READY: begin
        state_d = READY;
      end
      default: begin
        state_d = CLEAR;
      end
    endcase
  end

  // Outputs: busy follows the next state so it drops on the final sweep edge.
  always_comb begin
    busy_d      = (state_d == CLEAR);
    port_wr_c   = (state_q == READY) && write_enable;
    user_wr_c   = port_wr_c && !(ZERO_REG && (wr_addr == '0));
    mem_we_c    = !rst && ((state_q == CLEAR) || user_wr_c);
    mem_waddr_c = wr_addr;
    mem_wdata_c = data_in;
    if (state_q == CLEAR) begin
      mem_waddr_c = clr_cnt_q;
      mem_wdata_c = '0;
    end
  end

  // Storage array; contents are defined by the clear sweep, not by reset.
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      mem_q[mem_waddr_c] <= mem_wdata_c;
    end
  end

  // Read ports.
  for (genvar i = 0; i < NUM_READ; i++) begin : g_rd
    logic [ADDR_W-1:0] addr_c;
    assign addr_c = rd_addr[slice_lo(i, ADDR_W) +: ADDR_W];

    regfile_read_port #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG),
      .BYPASS   (BYPASS)
    ) u_port (
      .clk        (clk),
      .rst        (rst),
      .clear_i    (state_q == CLEAR),
      .rd_en_i    (rd_en[i]),
      .rd_addr_i  (addr_c),
      .wr_en_i    (port_wr_c),
      .wr_addr_i  (wr_addr),
      .wr_data_i  (data_in),
      .arr_data_i (mem_q[addr_c]),
      .rd_data_o  (rd_data[slice_lo(i, DATA_W) +: DATA_W])
    );
  end

  assign busy = busy_q;

endmodule

// File: tb/tb_register_file_mp.sv
// Bench for register_file_mp: three configurations driven in lockstep
// (default, no zero entry, no forwarding) against a behavioural model.
module tb_register_file_mp;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned NR = 2;
  localparam int unsigned ND = 3;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [NR-1:0]   rd_en = '0;
  logic [NR*AW-1:0] rd_addr = '0;
  logic            write_enable = 1'b0;
  logic [AW-1:0]   wr_addr = '0;
  logic [DW-1:0]   data_in = '0;

  logic [NR*DW-1:0] rd_all [ND];
  logic             busy_all [ND];

  always #5 clk = ~clk;

  register_file_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_READ(NR), .ZERO_REG(1'b1), .BYPASS(1'b1)) u_dut_a (
    .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_all[0]),
    .write_enable(write_enable), .wr_addr(wr_addr), .data_in(data_in), .busy(busy_all[0]));
  register_file_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_READ(NR), .ZERO_REG(1'b0), .BYPASS(1'b1)) u_dut_b (
    .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_all[1]),
    .write_enable(write_enable), .wr_addr(wr_addr), .data_in(data_in), .busy(busy_all[1]));
  register_file_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_READ(NR), .ZERO_REG(1'b1), .BYPASS(1'b0)) u_dut_c (
    .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_all[2]),
    .write_enable(write_enable), .wr_addr(wr_addr), .data_in(data_in), .busy(busy_all[2]));

  int n_checks = 0;
  int n_errors = 0;

  // Model state, shared timing across configurations.
  bit          zr [ND] = '{1'b1, 1'b0, 1'b1};
  bit          bp [ND] = '{1'b1, 1'b1, 1'b0};
  logic [DW-1:0] m [ND][32];
  logic [DW-1:0] exp_rd [ND][NR];
  bit          m_clear = 1'b1;
  int          m_cnt = 0;
  bit          m_busy = 1'b1;

  logic [DW-1:0] sb_q [$];

  task automatic check(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s act=%h exp=%h", tag, act, exp);
    end
  endtask

  // Advance the model by one edge using the currently driven inputs.
  task automatic model_step();
    logic [AW-1:0] a;
    if (rst) begin
      m_clear = 1'b1; m_cnt = 0; m_busy = 1'b1;
      for (int d = 0; d < ND; d++)
        for (int p = 0; p < NR; p++) exp_rd[d][p] = '0;
    end else if (m_clear) begin
      for (int d = 0; d < ND; d++) begin
        m[d][m_cnt] = '0;
        for (int p = 0; p < NR; p++) if (rd_en[p]) exp_rd[d][p] = '0;
      end
      if (m_cnt == 31) begin
        m_clear = 1'b0; m_busy = 1'b0;
      end
      m_cnt++;
    end else begin
      for (int d = 0; d < ND; d++) begin
        for (int p = 0; p < NR; p++) begin
          if (rd_en[p]) begin
            a = rd_addr[p*AW +: AW];
            if (zr[d] && a == 0) exp_rd[d][p] = '0;
            else if (bp[d] && write_enable && wr_addr == a) exp_rd[d][p] = data_in;
            else exp_rd[d][p] = m[d][a];
          end
        end
        if (write_enable && !(zr[d] && wr_addr == 0)) m[d][wr_addr] = data_in;
      end
    end
  endtask

  // One clock: push expectations, clock, pop and compare every output.
  task automatic tick();
    model_step();
    for (int d = 0; d < ND; d++)
      for (int p = 0; p < NR; p++) sb_q.push_back(exp_rd[d][p]);
    for (int d = 0; d < ND; d++) sb_q.push_back(DW'(m_busy));
    @(posedge clk);
    #1;
    for (int d = 0; d < ND; d++)
      for (int p = 0; p < NR; p++)
        check($sformatf("rd_d%0d_p%0d", d, p), rd_all[d][p*DW +: DW], sb_q.pop_front());
    for (int d = 0; d < ND; d++)
      check($sformatf("busy_d%0d", d), DW'(busy_all[d]), sb_q.pop_front());
  endtask

  task automatic set_rd(input logic e0, input logic [AW-1:0] a0, input logic e1, input logic [AW-1:0] a1);
    rd_en = {e1, e0};
    rd_addr = {a1, a0};
  endtask

  task automatic set_wr(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    write_enable = we;
    wr_addr = a;
    data_in = d;
  endtask

  task automatic wait_sweep(input string tag);
    int n = 0;
    while (busy_all[0] === 1'b1 && n < 100) begin
      tick();
      n++;
    end
    check(tag, DW'(n), DW'(32));
  endtask

  initial begin
    // Reset and first sweep.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wait_sweep("busy_len_first");

    // Every entry reads 0 after the sweep.
    for (int i = 0; i < 32; i++) begin
      set_rd(1'b1, AW'(i), 1'b1, AW'(31 - i));
      tick();
    end

    // Basic write then dual-port read.
    set_rd(1'b0, '0, 1'b0, '0);
    set_wr(1'b1, 5'd5, 32'hDEADBEEF);
    tick();
    set_wr(1'b0, '0, '0);
    set_rd(1'b1, 5'd5, 1'b1, 5'd5);
    tick();
    check("basic_p0", rd_all[0][0 +: DW], 32'hDEADBEEF);
    check("basic_p1", rd_all[0][DW +: DW], 32'hDEADBEEF);

    // Zero entry.
    set_rd(1'b0, '0, 1'b0, '0);
    set_wr(1'b1, 5'd0, 32'h12345678);
    tick();
    set_wr(1'b0, '0, '0);
    set_rd(1'b1, 5'd0, 1'b0, '0);
    tick();
    check("zero_on", rd_all[0][0 +: DW], 32'h0);
    check("zero_off", rd_all[1][0 +: DW], 32'h12345678);

    // Forwarding vs old data.
    set_rd(1'b0, '0, 1'b0, '0);
    set_wr(1'b1, 5'd7, 32'h1);
    tick();
    set_wr(1'b1, 5'd7, 32'hA5A5A5A5);
    set_rd(1'b1, 5'd7, 1'b0, '0);
    tick();
    check("bypass_on", rd_all[0][0 +: DW], 32'hA5A5A5A5);
    check("bypass_off_old", rd_all[2][0 +: DW], 32'h1);
    set_wr(1'b0, '0, '0);
    tick();
    check("bypass_off_new", rd_all[2][0 +: DW], 32'hA5A5A5A5);

    // Read enable hold.
    set_rd(1'b0, '0, 1'b0, '0);
    set_wr(1'b1, 5'd3, 32'h33);
    tick();
    set_wr(1'b1, 5'd4, 32'h44);
    tick();
    set_wr(1'b0, '0, '0);
    set_rd(1'b0, '0, 1'b1, 5'd3);
    tick();
    set_rd(1'b0, '0, 1'b0, 5'd4);
    tick();
    check("hold_p1", rd_all[0][DW +: DW], 32'h33);

    // Random traffic.
    for (int i = 0; i < 200; i++) begin
      set_rd(1'($urandom), AW'($urandom), 1'($urandom), AW'($urandom));
      set_wr(1'($urandom), AW'($urandom_range(0, 7)), $urandom);
      tick();
    end

    // Reset mid-sweep with writes attempted while busy.
    set_rd(1'b0, '0, 1'b0, '0);
    set_wr(1'b1, 5'd20, 32'hFF);
    tick();
    set_wr(1'b0, '0, '0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_wr(1'b1, 5'd2, 32'hBEEF);
    for (int i = 0; i < 9; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wait_sweep("busy_len_restart");
    set_wr(1'b0, '0, '0);
    set_rd(1'b1, 5'd2, 1'b1, 5'd20);
    tick();
    check("sweep_e2", rd_all[0][0 +: DW], 32'h0);
    check("sweep_e20", rd_all[0][DW +: DW], 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
